// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module  : muldiv_unit_if
// Purpose : Request / write-back bundle between control path and muldiv_unit.
//           Carries is_word only when MULDIV_WORD_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic [4:0]      RD_in;
`ifdef MULDIV_WORD_EN
    logic            is_word;
`endif
    logic            busy;
    logic            done;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      RD;
    logic            RegWrite;

`ifdef MULDIV_WORD_EN
    modport master (
        output start, funct3, ReadData1, ReadData2, RD_in, is_word,
        input  busy, done, WriteData, RD, RegWrite
    );
    modport slave (
        input  start, funct3, ReadData1, ReadData2, RD_in, is_word,
        output busy, done, WriteData, RD, RegWrite
    );
`else
    modport master (
        output start, funct3, ReadData1, ReadData2, RD_in,
        input  busy, done, WriteData, RD, RegWrite
    );
    modport slave (
        input  start, funct3, ReadData1, ReadData2, RD_in,
        output busy, done, WriteData, RD, RegWrite
    );
`endif
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Purpose : Radix-2 iterative RV64M multiply/divide with start/busy/done.
//           Optional word ops (MULW/DIVW/...) under macro MULDIV_WORD_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  wire logic    clk,
    input  wire logic    reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] c_ONES = '1;
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_last;
    logic [2:0]        r_f3;
    logic              r_word;
    logic              r_neg;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_op;
    logic              r_busy;
    logic              r_done;
    logic              r_regwrite;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;

    logic w_word;
`ifdef MULDIV_WORD_EN
    assign w_word = bus.is_word;
`else
    assign w_word = 1'b0;
`endif

    // Accept-side decode: signedness, operand magnitudes and fast-path cases
    logic            w_div;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_rs1_sx;
    logic [XLEN-1:0] w_min;
    logic            w_dz;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    assign w_div   = bus.funct3[2];
    assign w_a_sgn = w_div ? ~bus.funct3[0]
                           : ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)) && !w_word;
    assign w_b_sgn = w_div ? ~bus.funct3[0]
                           : (bus.funct3 == 3'b001) && !w_word;

    assign w_a_ext = !w_word ? bus.ReadData1
                   : (w_a_sgn ? f_sext32(bus.ReadData1[31:0])
                              : {{(XLEN-32){1'b0}}, bus.ReadData1[31:0]});
    assign w_b_ext = !w_word ? bus.ReadData2
                   : (w_b_sgn ? f_sext32(bus.ReadData2[31:0])
                              : {{(XLEN-32){1'b0}}, bus.ReadData2[31:0]});

    assign w_a_neg  = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg  = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_rs1_sx = w_word ? f_sext32(bus.ReadData1[31:0]) : bus.ReadData1;
    assign w_min    = w_word ? f_sext32(32'h8000_0000) : c_MIN;

    assign w_dz      = w_div && (w_b_ext == '0);
    assign w_ovf     = w_div && !bus.funct3[0] && (w_a_ext == w_min) && (w_b_ext == c_ONES);
    assign w_special = w_dz | w_ovf;
    assign w_spec_res = bus.funct3[1] ? (w_dz ? w_rs1_sx : '0)
                                      : (w_dz ? c_ONES : w_a_ext);

    // Iteration datapath: {r_acc, r_lo} is product or remainder/quotient pair
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    assign w_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_op} : '0);
    assign w_shift = {r_acc, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_op});
    assign w_diff  = w_shift[XLEN-1:0] - r_op;

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_dval;
    logic [XLEN-1:0]   w_dval_s;
    logic [XLEN-1:0]   w_res;

    assign w_prod   = {r_acc, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_dval   = r_f3[1] ? r_acc : r_lo;
    assign w_dval_s = r_neg ? -w_dval : w_dval;

    always_comb begin
        w_res = '0;
        if (r_f3[2])
            w_res = r_word ? f_sext32(w_dval_s[31:0]) : w_dval_s;
        else if (r_word)
            w_res = f_sext32(r_lo[XLEN-1:XLEN-32]);
        else if (r_f3[1:0] == 2'b00)
            w_res = w_prod_s[XLEN-1:0];
        else
            w_res = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= '0;
            r_f3       <= '0;
            r_word     <= 1'b0;
            r_neg      <= 1'b0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_op       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_regwrite <= 1'b0;
            r_wdata    <= '0;
            r_rd       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_f3   <= bus.funct3;
                        r_rd   <= bus.RD_in;
                        r_word <= w_word;
                        r_cnt  <= '0;
                        r_last <= w_word ? CNT_W'(31) : CNT_W'(XLEN-1);
                        r_busy <= 1'b1;
                        if (w_special) begin
                            r_wdata    <= w_spec_res;
                            r_done     <= 1'b1;
                            r_regwrite <= |bus.RD_in;
                            r_state    <= S_DONE;
                        end else begin
                            r_acc   <= '0;
                            r_neg   <= (w_div && bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                            r_op    <= w_div ? w_b_mag : w_a_mag;
                            // Word divides park the dividend in the top half
                            if (w_div)
                                r_lo <= w_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                            else
                                r_lo <= w_b_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_f3[2]) begin
                        r_acc <= w_ge ? w_diff : w_shift[XLEN-1:0];
                        r_lo  <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= w_sum[XLEN:1];
                        r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == r_last)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_wdata    <= w_res;
                    r_done     <= 1'b1;
                    r_regwrite <= |r_rd;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_regwrite <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.WriteData = r_wdata;
    assign bus.RD        = r_rd;
    assign bus.RegWrite  = r_regwrite;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Purpose : Directed self-checking bench for muldiv_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(64)) bus ();

    muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op; returns in the cycle done is seen (or at the budget)
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int repulse,
                          output int lat, output bit busy_ok);
        bus.funct3    = f3;
        bus.ReadData1 = a;
        bus.ReadData2 = b;
        bus.RD_in     = rd;
        bus.start     = 1'b1;
        tick;
        bus.start     = 1'b0;
        bus.ReadData1 = {$urandom, $urandom};
        bus.ReadData2 = {$urandom, $urandom};
        bus.RD_in     = 5'd17;
        bus.funct3    = ~f3;
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == repulse) begin
                bus.start     = 1'b1;
                bus.funct3    = 3'b101;
                bus.ReadData1 = 64'd100;
                bus.ReadData2 = 64'd7;
                bus.RD_in     = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            tick;
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic op_chk(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input int repulse,
                          input logic [63:0] exp_data, input int exp_lat);
        int lat;
        bit busy_ok;
        run_op(f3, a, b, rd, repulse, lat, busy_ok);
        chk({tag, "_lat"},      64'(lat),          64'(exp_lat));
        chk({tag, "_data"},     bus.WriteData,     exp_data);
        chk({tag, "_rd"},       64'(bus.RD),       64'(rd));
        chk({tag, "_regwrite"}, 64'(bus.RegWrite), 64'(rd != 5'd0));
        chk({tag, "_busy"},     64'(busy_ok),      64'd1);
        tick;
        chk({tag, "_done_clr"}, 64'(bus.done),     64'd0);
        chk({tag, "_busy_clr"}, 64'(bus.busy),     64'd0);
    endtask

    initial begin
        int  lat;
        bit  busy_ok;
        bit  saw_done;

        bus.start     = 1'b0;
        bus.funct3    = 3'b000;
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        bus.RD_in     = '0;
`ifdef MULDIV_WORD_EN
        bus.is_word   = 1'b0;
`endif
        repeat (3) tick;
        chk("rst_busy",  64'(bus.busy),     64'd0);
        chk("rst_done",  64'(bus.done),     64'd0);
        chk("rst_rw",    64'(bus.RegWrite), 64'd0);
        chk("rst_wdata", bus.WriteData,     64'd0);
        chk("rst_rd",    64'(bus.RD),       64'd0);
        reset = 1'b1;
        tick;

        op_chk("mul_7xm3",  3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 0, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        op_chk("mulhu_max", 3'b011, '1, '1, 5'd1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        op_chk("mulh_m1",   3'b001, '1, '1, 5'd2, 0, 64'd0, 66);
        op_chk("mulhsu",    3'b010, '1, 64'd2, 5'd3, 0, '1, 66);
        op_chk("div_m7_2",  3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        op_chk("rem_m7_2",  3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 0, '1, 66);
        op_chk("divu_100_7", 3'b101, 64'd100, 64'd7, 5'd8, 0, 64'd14, 66);
        op_chk("remu_100_7", 3'b111, 64'd100, 64'd7, 5'd9, 0, 64'd2, 66);

        op_chk("divu_by0", 3'b101, 64'd5, 64'd0, 5'd10, 0, '1, 1);
        op_chk("div_by0",  3'b100, 64'd5, 64'd0, 5'd10, 0, '1, 1);
        op_chk("rem_by0",  3'b110, 64'd5, 64'd0, 5'd11, 0, 64'd5, 1);
        op_chk("div_ovf",  3'b100, 64'h8000_0000_0000_0000, '1, 5'd12, 0, 64'h8000_0000_0000_0000, 1);
        op_chk("rem_ovf",  3'b110, 64'h8000_0000_0000_0000, '1, 5'd13, 0, 64'd0, 1);

        op_chk("mul_repulse", 3'b000, 64'h1234, 64'h10, 5'd5, 10, 64'h12340, 66);
        op_chk("divu_rd0",    3'b101, 64'd100, 64'd7, 5'd0, 0, 64'd14, 66);

        // Start held through DONE is taken only once the unit is back in IDLE
        run_op(3'b000, 64'd3, 64'd5, 5'd4, 0, lat, busy_ok);
        chk("b2b_first", bus.WriteData, 64'd15);
        bus.funct3    = 3'b101;
        bus.ReadData1 = 64'd5;
        bus.ReadData2 = 64'd0;
        bus.RD_in     = 5'd6;
        bus.start     = 1'b1;
        tick;
        chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
        chk("b2b_idle_done", 64'(bus.done), 64'd0);
        tick;
        bus.start = 1'b0;
        chk("b2b_done",  64'(bus.done),  64'd1);
        chk("b2b_data",  bus.WriteData,  '1);
        chk("b2b_rd",    64'(bus.RD),    64'd6);
        tick;

        // Abort a MUL mid-flight
        bus.funct3    = 3'b000;
        bus.ReadData1 = 64'd9;
        bus.ReadData2 = 64'd9;
        bus.RD_in     = 5'd3;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (29) tick;
        chk("abort_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        tick;
        chk("abort_busy",  64'(bus.busy),     64'd0);
        chk("abort_done",  64'(bus.done),     64'd0);
        chk("abort_rw",    64'(bus.RegWrite), 64'd0);
        chk("abort_wdata", bus.WriteData,     64'd0);
        reset    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        op_chk("mul_after_rst", 3'b000, 64'd9, 64'd9, 5'd3, 0, 64'd81, 66);

`ifdef MULDIV_WORD_EN
        bus.is_word = 1'b1;
        op_chk("divw_m7_2", 3'b100, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd4, 0, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        op_chk("divw_ovf",  3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd4, 0,
               64'hFFFF_FFFF_8000_0000, 1);
        op_chk("mulw",      3'b011, 64'hABCD_0000_7FFF_FFFF, 64'd2, 5'd4, 0, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        bus.is_word = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution stage.
- Consumes the two source operands read from the register file and produces a write-back triple (data, destination, write enable) that feeds the register file write port directly.
- Radix-2: one product/quotient bit per cycle, with a start/busy/done handshake so the control path can stall the PC while an operation is in flight.

Parameters:
- XLEN, 64, operand and result width (only 64 is supported).
- CNT_W, 7, width of the iteration counter (must hold XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- funct3  input  3  RV64M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ReadData1  input  XLEN  rs1 operand (multiplicand/dividend).
- ReadData2  input  XLEN  rs2 operand (multiplier/divisor).
- RD_in  input  5  destination register of the request.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle result-valid pulse.
- WriteData  output  XLEN  result; held until the next accept.
- RD  output  5  destination, latched at accept.
- RegWrite  output  1  equals done && (RD != 0).

Behaviour:
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start=1 latches funct3, RD_in, operand magnitudes, result-sign flags and cnt=0.
  - IDLE then goes to CALC, or straight to DONE for the special division cases below.
- CALC, one step per cycle, cnt increments each cycle:
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring subtract into remainder/quotient registers.
  - At cnt = XLEN-1 the state goes to FIX.
- FIX: applies the sign correction and selects the result. Next state is DONE.
  - MUL: low XLEN bits of the signed product.
  - MULH: high bits, signed x signed.
  - MULHSU: high bits, signed rs1 x unsigned rs2.
  - MULHU: high bits, unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - Unsigned ops skip all negation.
- DONE: done=1 for exactly one cycle, WriteData/RD valid, then IDLE.
- Latency: start sampled in cycle 0 gives done in cycle XLEN+2 (66). Special cases give done in cycle 1.
- Special division cases, detected at accept (fast path):
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = rs1.
  - Overflow (DIV/REM with rs1 = 0x8000_0000_0000_0000, rs2 = -1): quotient = rs1, remainder = 0.
- start while busy (CALC/FIX/DONE) is ignored: no queuing and no effect on the in-flight op.
- Back-to-back: start may be asserted in the DONE cycle, but it is not accepted until IDLE (next cycle).
- Reset (reset=0 at a rising edge):
  - State = IDLE; busy, done, RegWrite = 0; WriteData = 0; RD = 0; counter and datapath registers = 0.
  - Reset mid-operation aborts the op with no write-back.
- Operands are captured at accept; ReadData1/ReadData2 may change freely afterwards.

Optional Feature:
- Macro: MULDIV_WORD_EN.
- Defined:
  - Adds input port is_word (1 bit) for MULW/DIVW/DIVUW/REMW/REMUW.
  - Word ops use the low 32 bits of each operand and run 32 iterations (done in cycle 34).
  - The 32-bit result is sign-extended to XLEN.
  - Word special cases follow the same rules with 32-bit values (DIVW 0x8000_0000 / -1 = 0xFFFF_FFFF_8000_0000).
  - is_word with funct3 001/010/011 is treated as MULW.
- Undefined: no is_word port; all ops are 64-bit.

Test Plan:
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD, RD_in=5: done in cycle 66, WriteData=0xFFFF_FFFF_FFFF_FFEB, RD=5, RegWrite=1, busy high cycles 1-66.
- MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF gives 0xFFFF_FFFF_FFFF_FFFE; MULH of the same operands gives 0.
- DIV -7/2 gives 0xFFFF_FFFF_FFFF_FFFD; REM -7%2 gives 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 gives 14; REMU gives 2.
- Special cases, each with done in cycle 1:
  - DIVU 5/0 gives 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5%0 gives 5.
  - DIV 0x8000_0000_0000_0000 / -1 gives 0x8000_0000_0000_0000.
  - REM of the same operands gives 0.
- start re-pulsed with new operands at cycle 10, and RD_in=0 on a separate op: the first result is unchanged in cycle 66; the RD_in=0 op gives done=1 with RegWrite=0.
- reset=0 at cycle 30 of a MUL: busy, done, RegWrite, WriteData = 0 next cycle, no done pulse; a new start after release completes normally in 66 cycles.
